// File: rtl/c2c_traffic_chk.sv
// Sequence-numbered traffic generator and lock/error checker for one 64-bit C2C ring direction.
// Optional C2C_CHK_BITERR_EN adds a saturating per-bit error counter (bit_err_cnt).
module c2c_traffic_chk #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             gen_en,
    input  logic             inject_err,
    input  logic             clr_cnt,
    output logic [63:0]      tx_data,
    input  logic [63:0]      rx_data,
    output logic             locked,
`ifdef C2C_CHK_BITERR_EN
    output logic [CNT_W-1:0] bit_err_cnt,
`endif
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0] LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_CNT);

    state_t      state;
    logic [31:0] seq, exp_seq;
    logic [7:0]  good, bad;
    logic        inj_pend;

    logic        inj, idle, fmt_ok, match, cnt_word, cnt_err;
    logic [63:0] w_exp;

    assign inj      = inject_err | inj_pend;
    assign idle     = (rx_data == 64'h0);
    assign fmt_ok   = (rx_data[63:32] == ~rx_data[31:0]);
    assign w_exp    = {exp_seq, ~exp_seq};
    assign match    = (rx_data == w_exp);
    assign cnt_word = !idle && (state == LOCKED);
    assign cnt_err  = cnt_word && !match;

    // Generator: an injection requested while idle waits for the next real word.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            tx_data  <= 64'h0;
            seq      <= 32'h0;
            inj_pend <= 1'b0;
        end else if (gen_en) begin
            tx_data  <= {seq, ~seq} ^ {63'b0, inj};
            seq      <= seq + 32'd1;
            inj_pend <= 1'b0;
        end else begin
            tx_data  <= 64'h0;
            if (inject_err)
                inj_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= HUNT;
            locked  <= 1'b0;
            exp_seq <= 32'h0;
            good    <= 8'd0;
            bad     <= 8'd0;
        end else if (!idle) begin
            unique case (state)
                HUNT: begin
                    if (fmt_ok) begin
                        exp_seq <= rx_data[63:32] + 32'd1;
                        good    <= 8'd1;
                        if (LOCK_C == 8'd1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            bad    <= 8'd0;
                        end else begin
                            state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (match) begin
                        exp_seq <= exp_seq + 32'd1;
                        good    <= good + 8'd1;
                        if (good + 8'd1 == LOCK_C) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            bad    <= 8'd0;
                        end
                    end else begin
                        state <= HUNT;
                        good  <= 8'd0;
                    end
                end
                LOCKED: begin
                    exp_seq <= exp_seq + 32'd1;
                    if (match) begin
                        bad <= 8'd0;
                    end else begin
                        bad <= bad + 8'd1;
                        if (bad + 8'd1 == UNLOCK_C) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            good   <= 8'd0;
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Counters saturate; clear beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (Reset || clr_cnt) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (cnt_word && word_cnt != '1)
                word_cnt <= word_cnt + CNT_W'(1);
            if (cnt_err && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

`ifdef C2C_CHK_BITERR_EN
    function automatic logic [6:0] popcnt(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++)
            n = n + 7'(v[i]);
        return n;
    endfunction

    logic                be_vld;
    logic [6:0]          be_pop;
    logic [CNT_W+7:0]    be_sum;

    assign be_sum = (CNT_W+8)'(bit_err_cnt) + (CNT_W+8)'(be_pop);

    // Popcount is registered first so the wide adder tree stays off the compare path.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            be_vld      <= 1'b0;
            be_pop      <= 7'd0;
            bit_err_cnt <= '0;
        end else begin
            be_vld <= cnt_err;
            be_pop <= popcnt(rx_data ^ w_exp);
            if (clr_cnt)
                bit_err_cnt <= '0;
            else if (be_vld)
                bit_err_cnt <= (|be_sum[CNT_W+7:CNT_W]) ? '1 : be_sum[CNT_W-1:0];
        end
    end
`endif
endmodule
